mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single block-wide memory port between N cache-side requesters (I-cache refill, D-cache refill/writeback).
//  Round-robin arbitration; sequences the memory's active-low Req_Low/Rdy_Low handshake; latches addr/data per access.
//  Sits between the cache controllers and the memory wrapper; sole driver of the memory's Req_Low/addr/din/Wr.
// PARAMETERS
//  N        2     number of requesters (>=2)
//  ADDR_W   10    memory block-address width
//  BLK_W    `Memory_Block_Size (128)  data block width
//  TIMEOUT  16    max cycles in ACCESS waiting for Rdy_Low low; 0 disables watchdog
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rst          in   1         synchronous reset, active-high
//  req          in   N         per-requester request; held high until matching ack
//  req_wr       in   N         1=write block, 0=read block
//  req_addr     in   N*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N*BLK_W   flat; requester i at [i*BLK_W +: BLK_W]
//  ack          out  N         one-cycle completion pulse, one-hot
//  rdata        out  BLK_W     read block; valid in the ack cycle, held until next ack
//  err          out  1         pulses with ack when watchdog expired (access failed)
//  busy         out  1         high in any state except IDLE
//  mem_Req_Low  out  1         to memory Req_Low (active low)
//  mem_addr     out  ADDR_W    to memory addr
//  mem_din      out  BLK_W     to memory din
//  mem_Wr       out  1         to memory Wr
//  mem_dout     in   BLK_W     from memory dout
//  mem_Rdy_Low  in   1         from memory Rdy_Low (active low; memory registers it from Req_Low, 1-cycle lag)
// BEHAVIOUR
//  Reset: state=RECOVER, mem_Req_Low=1, mem_Wr=0, mem_addr=0, mem_din=0, ack=0, err=0, rdata=0, rr_ptr=0.
//  All outputs registered. FSM states IDLE, ACCESS, RECOVER:
//   IDLE: if |req: winner = first set bit of req scanning from rr_ptr upward (wrapping mod N);
//         latch mem_addr/mem_din/mem_Wr from the winner, mem_Req_Low<=0, rr_ptr<=(winner+1)%N, timeout count<=0 -> ACCESS.
//   ACCESS: addr/din/Wr held stable. On edge with mem_Rdy_Low==0: rdata<=mem_dout (reads only; writes leave rdata),
//         ack[winner]<=1, mem_Req_Low<=1, mem_Wr<=0 -> RECOVER.
//         Else count++; if TIMEOUT!=0 and count==TIMEOUT-1: same as completion but err<=1 and rdata unchanged.
//   RECOVER: ack/err cleared; wait for mem_Rdy_Low==1 (stale-ready guard), then -> IDLE.
//  Latency: req high before edge E0 -> grant at E0, memory Rdy_Low low after E1, ack high after E2 (3 cycles).
//         Min spacing between accesses: 5 cycles (IDLE, ACCESS x2, RECOVER x2).
//  Write timing: memory registers wea from Wr; holding Wr/addr/din until Rdy_Low is seen guarantees the write edge.
//  Boundaries:
//   - simultaneous req: rr_ptr decides; rr_ptr advances only on grant, never on idle cycles.
//   - requester must drop req in the cycle after ack; req re-sampled only in IDLE, so no double-grant.
//   - req dropped or addr/wdata changed mid-ACCESS: ignored; access completes and ack still pulses.
//   - rst mid-ACCESS: mem_Req_Low forced 1 same edge; RECOVER absorbs the still-low Rdy_Low; no ack issued.
//   - counter width $clog2(TIMEOUT+1); no wrap because it stops at TIMEOUT-1.
// STRUCTURE
//  data_def.v (shared include): `Memory_Block_Size, add `Memory_Addr_Width (10), `ARB_IDLE/`ARB_ACCESS/`ARB_RECOVER encodings.
//  One sub-module: rr_picker (combinational: req[N], ptr -> one-hot grant + index); fsm/datapath in mem_arbiter.
// TESTING (bench instantiates mem_arbiter + memory model with 1-cycle registered Rdy_Low, N=2)
//  - Reset, no req: mem_Req_Low=1, busy drops after 2 cycles (RECOVER exit), ack=0 for 20 cycles.
//  - Req0 read addr 0x005 with memory holding 0xA5..A5: ack=2'b01 exactly 3 cycles after req, rdata=0xA5..A5, err=0.
//  - Req1 write 0x3FF data 0x1234.., then req0 read 0x3FF: read returns 0x1234..; mem_Wr low after write ack.
//  - req=2'b11 held continuously 6 accesses: acks alternate 01,10,01,... ; spacing exactly 5 cycles.
//  - Memory model never asserts Rdy_Low, TIMEOUT=16: ack+err pulse 16 cycles after entering ACCESS; next req serviced.
//  - rst asserted the cycle after grant: no ack; mem_Req_Low=1 next edge; first post-reset access completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-port arbiter: default memory geometry,
//   the arbiter FSM state encoding and a small modulo-increment helper used
//   for the round-robin pointer.
package mem_arbiter_pkg;

  localparam int MEM_BLOCK_SIZE = 128;  // data block width in bits
  localparam int MEM_ADDR_WIDTH = 10;   // block-address width

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RECOVER = 2'd2
  } arb_state_e;

  // (v + 1) mod n, for 0 <= v < n
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin picker. Scans req starting at position ptr and
//   wrapping modulo N; the first set bit wins.
// Ports
//   req    in  N       request vector
//   ptr    in  IDX_W   index with highest priority this cycle
//   grant  out N       one-hot winner (all zero when no request)
//   idx    out IDX_W   winner index (0 when no request)
//   any    out 1       at least one request present
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Position k steps above p, wrapped into 0..N-1.
  function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[rot(ptr, k)]) begin
        any = 1'b1;
        idx = rot(ptr, k);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = any && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between N requesters with round-robin priority and
//   sequences the memory's active-low Req_Low/Rdy_Low handshake. Address, data
//   and direction are latched at grant and held for the whole access.
// Ports
//   clk, rst              clock / synchronous active-high reset
//   req, req_wr           per-requester request and write flag (held until ack)
//   req_addr, req_wdata   flat per-requester address / write block
//   ack                   one-cycle one-hot completion pulse
//   rdata                 read block, updated on read completion only
//   err                   pulses with ack when the ready watchdog expired
//   busy                  high whenever the FSM is not IDLE
//   mem_Req_Low, mem_addr, mem_din, mem_Wr   memory request side
//   mem_dout, mem_Rdy_Low                    memory response side
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int ADDR_W  = MEM_ADDR_WIDTH,
  parameter int BLK_W   = MEM_BLOCK_SIZE,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        req_wr,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic [N*BLK_W-1:0]  req_wdata,
  output logic [N-1:0]        ack,
  output logic [BLK_W-1:0]    rdata,
  output logic                err,
  output logic                busy,
  output logic                mem_Req_Low,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BLK_W-1:0]    mem_din,
  output logic                mem_Wr,
  input  logic [BLK_W-1:0]    mem_dout,
  input  logic                mem_Rdy_Low
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e        state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [N-1:0]      winner_oh_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [N-1:0]      ack_reg;
  logic              err_reg;
  logic [BLK_W-1:0]  rdata_reg;
  logic              mem_req_low_reg;
  logic              mem_wr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [BLK_W-1:0]  mem_din_reg;

  logic [N-1:0]      pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  // Unpacked views of the flat request buses.
  logic [ADDR_W-1:0] addr_arr [N];
  logic [BLK_W-1:0]  wdata_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*BLK_W +: BLK_W];
  end

  rr_picker #(.N(N), .IDX_W(IDX_W)) u_picker (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // Start in RECOVER so a Rdy_Low left low by an interrupted access is
      // drained before the next grant.
      state_reg       <= ARB_RECOVER;
      rr_ptr_reg      <= '0;
      winner_oh_reg   <= '0;
      count_reg       <= '0;
      ack_reg         <= '0;
      err_reg         <= 1'b0;
      rdata_reg       <= '0;
      mem_req_low_reg <= 1'b1;
      mem_wr_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_din_reg     <= '0;
    end else begin
      ack_reg <= '0;
      err_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            winner_oh_reg   <= pick_grant;
            mem_addr_reg    <= addr_arr[pick_idx];
            mem_din_reg     <= wdata_arr[pick_idx];
            mem_wr_reg      <= req_wr[pick_idx];
            mem_req_low_reg <= 1'b0;
            rr_ptr_reg      <= IDX_W'(wrap_inc(int'(pick_idx), N));
            count_reg       <= '0;
            state_reg       <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (!mem_Rdy_Low) begin
            if (!mem_wr_reg) rdata_reg <= mem_dout;
            ack_reg         <= winner_oh_reg;
            mem_req_low_reg <= 1'b1;
            mem_wr_reg      <= 1'b0;
            state_reg       <= ARB_RECOVER;
          end else if (TIMEOUT != 0 && count_reg == CNT_LAST) begin
            // Watchdog: finish the access as failed, rdata untouched.
            ack_reg         <= winner_oh_reg;
            err_reg         <= 1'b1;
            mem_req_low_reg <= 1'b1;
            mem_wr_reg      <= 1'b0;
            state_reg       <= ARB_RECOVER;
          end else if (TIMEOUT != 0) begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        ARB_RECOVER: begin
          // Rdy_Low lags Req_Low by a cycle; wait for it to return high so a
          // stale ready is never taken as completion of the next access.
          if (mem_Rdy_Low) state_reg <= ARB_IDLE;
        end
        default: state_reg <= ARB_RECOVER;
      endcase
    end
  end

  assign ack         = ack_reg;
  assign err         = err_reg;
  assign rdata       = rdata_reg;
  assign busy        = (state_reg != ARB_IDLE);
  assign mem_Req_Low = mem_req_low_reg;
  assign mem_Wr      = mem_wr_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_din     = mem_din_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (N=2, 10-bit address, 128-bit blocks,
//   TIMEOUT=16) with a memory model that registers Rdy_Low one cycle after
//   Req_Low. A table of single-requester accesses is followed by hand-written
//   sequences for arbitration, watchdog and reset-in-flight.
module tb_mem_arbiter;

  localparam int N = 2;
  localparam int AW = 10;
  localparam int BW = 128;

  localparam logic [BW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [BW-1:0] PAT_12 = {8{16'h1234}};
  localparam logic [BW-1:0] PAT_DE = {4{32'hDEADBEEF}};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_wdata;
  logic [N-1:0]  ack;
  logic [BW-1:0] rdata;
  logic          err;
  logic          busy;
  logic          mem_Req_Low;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_din;
  logic          mem_Wr;
  logic [BW-1:0] mem_dout;
  logic          mem_Rdy_Low;

  logic          never_ready;
  logic          preload;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .ADDR_W(AW), .BLK_W(BW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .busy        (busy),
    .mem_Req_Low (mem_Req_Low),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_Wr      (mem_Wr),
    .mem_dout    (mem_dout),
    .mem_Rdy_Low (mem_Rdy_Low)
  );

  // Memory model: registered read data and registered, active-low ready.
  logic [BW-1:0] mem_arr [1024];
  always @(posedge clk) begin
    if (preload) begin
      mem_arr[5] <= PAT_A5;
    end else if (!mem_Req_Low && mem_Wr) begin
      mem_arr[mem_addr] <= mem_din;
    end
    mem_dout    <= mem_arr[mem_addr];
    mem_Rdy_Low <= mem_Req_Low | never_ready;
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access from requester `who`; returns the number of negedges from
  // raising req to the first nonzero ack (capped at 40).
  task automatic run_access(input int who, input logic wr, input logic [AW-1:0] addr,
                            input logic [BW-1:0] wd, output int lat,
                            output logic [N-1:0] ack_s, output logic err_s);
    req_wr[who]             = wr;
    req_addr[who*AW +: AW]  = addr;
    req_wdata[who*BW +: BW] = wd;
    req[who]                = 1'b1;
    lat   = 0;
    ack_s = '0;
    err_s = 1'b0;
    while (ack_s == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
      ack_s = ack;
      err_s = err;
    end
    req[who] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, BW'(busy), BW'(0));
  endtask

  typedef struct {
    int              who;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   wdata;
    logic [N-1:0]    exp_ack;
    logic [BW-1:0]   exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    int lat;
    logic [N-1:0] a;
    logic e;
    int seen, last, cyc;

    // who, wr, addr, wdata, ack, rdata after completion
    vecs[0] = '{0, 1'b0, 10'h005, '0,     2'b01, PAT_A5};
    vecs[1] = '{1, 1'b1, 10'h3FF, PAT_12, 2'b10, PAT_A5};
    vecs[2] = '{0, 1'b0, 10'h3FF, '0,     2'b01, PAT_12};
    vecs[3] = '{1, 1'b0, 10'h005, '0,     2'b10, PAT_A5};
    vecs[4] = '{0, 1'b1, 10'h001, PAT_DE, 2'b01, PAT_A5};
    vecs[5] = '{1, 1'b0, 10'h001, '0,     2'b10, PAT_DE};

    rst = 1'b1; preload = 1'b1; never_ready = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_low", BW'(mem_Req_Low), BW'(1));
    check("rst_wr",      BW'(mem_Wr),      BW'(0));
    check("rst_addr",    BW'(mem_addr),    BW'(0));
    check("rst_din",     mem_din,          BW'(0));
    check("rst_ack",     BW'(ack),         BW'(0));
    check("rst_err",     BW'(err),         BW'(0));
    check("rst_rdata",   rdata,            BW'(0));
    check("rst_busy",    BW'(busy),        BW'(1));
    rst = 1'b0; preload = 1'b0;

    cyc = 0;
    while (busy && cyc < 2) begin @(negedge clk); cyc++; end
    check("busy_drop_after_reset", BW'(busy), BW'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_no_ack", BW'(ack), BW'(0));
    end
    check("idle_req_low", BW'(mem_Req_Low), BW'(1));

    // Table of single-requester accesses
    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, a, e);
      $display("vec %0d: who=%0d wr=%0b addr=%h ack=%b lat=%0d err=%0b rdata=%h",
               i, vecs[i].who, vecs[i].wr, vecs[i].addr, a, lat, e, rdata);
      check($sformatf("vec%0d_ack", i),     BW'(a),           BW'(vecs[i].exp_ack));
      check($sformatf("vec%0d_latency", i), BW'(lat),         BW'(3));
      check($sformatf("vec%0d_err", i),     BW'(e),           BW'(0));
      check($sformatf("vec%0d_rdata", i),   rdata,            vecs[i].exp_rdata);
      check($sformatf("vec%0d_wr_low", i),  BW'(mem_Wr),      BW'(0));
      check($sformatf("vec%0d_req_low", i), BW'(mem_Req_Low), BW'(1));
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Both requesters held: strict alternation, 5-cycle spacing
    req_addr = {10'h3FF, 10'h005};
    req_wr   = '0;
    req      = 2'b11;
    seen = 0; last = 0; cyc = 0;
    while (seen < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        $display("rr ack %0d: ack=%b cycle=%0d rdata=%h", seen, ack, cyc, rdata);
        check($sformatf("rr%0d_ack", seen), BW'(ack), (seen % 2 == 0) ? BW'(2'b01) : BW'(2'b10));
        check($sformatf("rr%0d_rdata", seen), rdata, (seen % 2 == 0) ? PAT_A5 : PAT_12);
        if (seen > 0) check($sformatf("rr%0d_spacing", seen), BW'(cyc - last), BW'(5));
        last = cyc;
        seen++;
        if (seen == 6) req = '0;
      end
    end
    check("rr_ack_count", BW'(seen), BW'(6));
    wait_idle("rr_idle");

    // Watchdog: memory never answers
    never_ready = 1'b1;
    run_access(0, 1'b0, 10'h005, '0, lat, a, e);
    $display("timeout: ack=%b lat=%0d err=%0b rdata=%h", a, lat, e, rdata);
    check("to_ack",     BW'(a),   BW'(2'b01));
    check("to_err",     BW'(e),   BW'(1));
    check("to_latency", BW'(lat), BW'(17));
    check("to_rdata",   rdata,    PAT_12);
    never_ready = 1'b0;
    @(negedge clk);
    check("to_err_pulse", BW'(err), BW'(0));
    check("to_ack_pulse", BW'(ack), BW'(0));
    wait_idle("to_idle");
    run_access(1, 1'b0, 10'h005, '0, lat, a, e);
    $display("after timeout: ack=%b lat=%0d err=%0b rdata=%h", a, lat, e, rdata);
    check("post_to_ack",     BW'(a),   BW'(2'b10));
    check("post_to_latency", BW'(lat), BW'(3));
    check("post_to_err",     BW'(e),   BW'(0));
    check("post_to_rdata",   rdata,    PAT_A5);
    wait_idle("post_to_idle");

    // Reset arriving the cycle after grant
    req_wr[0] = 1'b0; req_addr[AW-1:0] = 10'h005; req[0] = 1'b1;
    @(negedge clk);
    check("rstmid_granted", BW'(mem_Req_Low), BW'(0));
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-access: req_low=%0b ack=%b busy=%0b", mem_Req_Low, ack, busy);
    check("rstmid_req_low", BW'(mem_Req_Low), BW'(1));
    check("rstmid_ack",     BW'(ack),         BW'(0));
    check("rstmid_rdata",   rdata,            BW'(0));
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    check("rstmid_stale_guard", BW'(busy), BW'(1));
    check("rstmid_ack2",        BW'(ack),  BW'(0));
    @(negedge clk);
    check("rstmid_recover_exit", BW'(busy), BW'(0));
    run_access(1, 1'b0, 10'h3FF, '0, lat, a, e);
    $display("post-reset access: ack=%b lat=%0d err=%0b rdata=%h", a, lat, e, rdata);
    check("post_rst_ack",     BW'(a),   BW'(2'b10));
    check("post_rst_latency", BW'(lat), BW'(3));
    check("post_rst_rdata",   rdata,    PAT_12);
    wait_idle("post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
